// File: rtl/pipeline_control_pkg.sv
// Shared definitions for the pipeline control block: FSM encoding,
// EX/MEM memory-control field layout and the default memory timeout.
package pipeline_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_e;

   localparam int MEM_WR          = 1;
   localparam int MEM_RD          = 0;
   localparam int MEM_TIMEOUT_DEF = 15;

   function automatic logic mem_access(input logic [1:0] m);
      return m[MEM_WR] | m[MEM_RD];
   endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// Data-memory handshake between the EX/MEM stage, the control block and memory.
interface pipeline_control_if;
   logic [1:0] i_exmem_M;
   logic       i_dmem_ack;
   logic       o_dmem_req;

   modport slave  (input  i_exmem_M, input  i_dmem_ack, output o_dmem_req);
   modport master (output i_exmem_M, output i_dmem_ack, input  o_dmem_req);
endinterface

// File: rtl/pipeline_control_hazard_detect.sv
// Load-use hazard detection between the load in ID/EX and the instruction in ID.
module hazard_detect (
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       idex_memread,
   input  logic [4:0] idex_rt,
   output logic       hazard
);

   logic rs_match_s;
   logic rt_match_s;

   assign rs_match_s = (idex_rt == id_rs);
   assign rt_match_s = id_uses_rt & (idex_rt == id_rt);
   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign hazard = idex_memread & (idex_rt != 5'd0) & (rs_match_s | rt_match_s);

endmodule

// File: rtl/pipeline_control.sv
// Pipeline stall/flush controller: load-use stalls, branch flushes and
// data-memory wait handling with a timeout into a sticky error state.
module pipeline_control
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [4:0]             i_id_rs,
   input  logic [4:0]             i_id_rt,
   input  logic                   i_id_uses_rt,
   input  logic                   i_idex_memread,
   input  logic [4:0]             i_idex_rt,
   input  logic                   i_ex_branch_taken,
   pipeline_control_if.slave      mem,
   output logic                   o_pc_en,
   output logic                   o_ifid_en,
   output logic                   o_ifid_flush,
   output logic                   o_idex_flush,
   output logic                   o_exmem_en,
   output logic                   o_memwb_flush,
   output logic                   o_error,
   output logic [STALL_CNT_W-1:0] o_stall_cnt
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0]      WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

   state_e                 state_r;
   state_e                 next_state_s;
   logic [WAIT_W-1:0]      wait_cnt_r;
   logic [STALL_CNT_W-1:0] stall_cnt_r;

   logic hazard_s;
   logic mem_s;
   logic run_pc_en_s;
   logic run_ifid_en_s;
   logic run_ifid_flush_s;
   logic run_idex_flush_s;

   logic pc_en_s;
   logic ifid_en_s;
   logic ifid_flush_s;
   logic idex_flush_s;
   logic exmem_en_s;
   logic memwb_flush_s;
   logic dmem_req_s;

   hazard_detect u_hazard_detect (
      .id_rs        (i_id_rs),
      .id_rt        (i_id_rt),
      .id_uses_rt   (i_id_uses_rt),
      .idex_memread (i_idex_memread),
      .idex_rt      (i_idex_rt),
      .hazard       (hazard_s)
   );

   assign mem_s = mem_access(mem.i_exmem_M);

   // Normal-flow enables; a taken branch overrides a simultaneous load-use stall.
   always_comb begin
      run_pc_en_s      = 1'b1;
      run_ifid_en_s    = 1'b1;
      run_ifid_flush_s = 1'b0;
      run_idex_flush_s = 1'b0;
      if (i_ex_branch_taken) begin
         run_ifid_flush_s = 1'b1;
         run_idex_flush_s = 1'b1;
      end else if (hazard_s) begin
         run_pc_en_s      = 1'b0;
         run_ifid_en_s    = 1'b0;
         run_idex_flush_s = 1'b1;
      end else begin
         run_pc_en_s      = 1'b1;
      end
   end

   // Next-state and control outputs for the current state.
   always_comb begin
      next_state_s  = state_r;
      pc_en_s       = run_pc_en_s;
      ifid_en_s     = run_ifid_en_s;
      ifid_flush_s  = run_ifid_flush_s;
      idex_flush_s  = run_idex_flush_s;
      exmem_en_s    = 1'b1;
      memwb_flush_s = 1'b0;
      dmem_req_s    = 1'b0;
      if (i_rst) begin
         next_state_s  = ST_RUN;
         pc_en_s       = 1'b0;
         ifid_en_s     = 1'b0;
         ifid_flush_s  = 1'b1;
         idex_flush_s  = 1'b1;
         exmem_en_s    = 1'b0;
         memwb_flush_s = 1'b1;
      end else begin
         case (state_r)
            ST_RUN: begin
               dmem_req_s = mem_s;
               // An unacknowledged access freezes the pipeline from its first cycle.
               if (mem_s && !mem.i_dmem_ack) begin
                  next_state_s  = ST_MEM_WAIT;
                  pc_en_s       = 1'b0;
                  ifid_en_s     = 1'b0;
                  ifid_flush_s  = 1'b0;
                  idex_flush_s  = 1'b0;
                  exmem_en_s    = 1'b0;
                  memwb_flush_s = 1'b1;
               end else begin
                  next_state_s  = ST_RUN;
               end
            end
            ST_MEM_WAIT: begin
               dmem_req_s = 1'b1;
               if (mem.i_dmem_ack) begin
                  next_state_s = ST_RUN;
               end else begin
                  pc_en_s       = 1'b0;
                  ifid_en_s     = 1'b0;
                  ifid_flush_s  = 1'b0;
                  idex_flush_s  = 1'b0;
                  exmem_en_s    = 1'b0;
                  memwb_flush_s = 1'b1;
                  if (wait_cnt_r == WAIT_LAST) begin
                     next_state_s = ST_ERR;
                  end else begin
                     next_state_s = ST_MEM_WAIT;
                  end
               end
            end
            ST_ERR: begin
               next_state_s  = ST_ERR;
               pc_en_s       = 1'b0;
               ifid_en_s     = 1'b0;
               ifid_flush_s  = 1'b0;
               idex_flush_s  = 1'b0;
               exmem_en_s    = 1'b0;
               memwb_flush_s = 1'b1;
            end
            default: begin
               next_state_s  = ST_RUN;
               pc_en_s       = 1'b0;
               ifid_en_s     = 1'b0;
               ifid_flush_s  = 1'b1;
               idex_flush_s  = 1'b1;
               exmem_en_s    = 1'b0;
               memwb_flush_s = 1'b1;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Memory wait counter: cleared on entry, counts unacknowledged wait cycles.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wait_cnt_r <= '0;
      end else if (state_r == ST_RUN && next_state_s == ST_MEM_WAIT) begin
         wait_cnt_r <= '0;
      end else if (state_r == ST_MEM_WAIT && !mem.i_dmem_ack) begin
         wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stall_cnt_r <= '0;
      end else if (!pc_en_s && stall_cnt_r != STALL_MAX) begin
         stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign o_pc_en        = pc_en_s;
   assign o_ifid_en      = ifid_en_s;
   assign o_ifid_flush   = ifid_flush_s;
   assign o_idex_flush   = idex_flush_s;
   assign o_exmem_en     = exmem_en_s;
   assign o_memwb_flush  = memwb_flush_s;
   assign mem.o_dmem_req = dmem_req_s;
   assign o_error        = (state_r == ST_ERR);
   assign o_stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control (default and 4-bit stall counter).
module tb_pipeline_control;

   // Output vector order: pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_flush, dmem_req, error
   localparam logic [7:0] V_NORMAL = 8'b1100_1000;
   localparam logic [7:0] V_RESET  = 8'b0011_0100;
   localparam logic [7:0] V_STALL  = 8'b0001_1000;
   localparam logic [7:0] V_BRANCH = 8'b1111_1000;
   localparam logic [7:0] V_FROZEN = 8'b0000_0110;
   localparam logic [7:0] V_ACKRUN = 8'b1100_1010;
   localparam logic [7:0] V_ERR    = 8'b0000_0101;
   localparam logic [7:0] V_RSTERR = 8'b0011_0101;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic [4:0] i_id_rs, i_id_rt, i_idex_rt;
   logic       i_id_uses_rt, i_idex_memread, i_ex_branch_taken;

   logic        o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_exmem_en, o_memwb_flush, o_error;
   logic [15:0] o_stall_cnt;
   logic        w4_pc_en, w4_ifid_en, w4_ifid_flush, w4_idex_flush, w4_exmem_en, w4_memwb_flush, w4_error;
   logic [3:0]  w4_stall_cnt;

   int checks = 0;
   int errors = 0;

   pipeline_control_if mem_if ();
   pipeline_control_if mem4_if ();

   assign mem4_if.i_exmem_M  = mem_if.i_exmem_M;
   assign mem4_if.i_dmem_ack = mem_if.i_dmem_ack;

   always #5 i_clk = ~i_clk;

   pipeline_control dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
      .i_id_uses_rt(i_id_uses_rt), .i_idex_memread(i_idex_memread), .i_idex_rt(i_idex_rt),
      .i_ex_branch_taken(i_ex_branch_taken), .mem(mem_if.slave),
      .o_pc_en(o_pc_en), .o_ifid_en(o_ifid_en), .o_ifid_flush(o_ifid_flush),
      .o_idex_flush(o_idex_flush), .o_exmem_en(o_exmem_en), .o_memwb_flush(o_memwb_flush),
      .o_error(o_error), .o_stall_cnt(o_stall_cnt)
   );

   pipeline_control #(.MEM_TIMEOUT(15), .STALL_CNT_W(4)) dut_w4 (
      .i_clk(i_clk), .i_rst(i_rst), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
      .i_id_uses_rt(i_id_uses_rt), .i_idex_memread(i_idex_memread), .i_idex_rt(i_idex_rt),
      .i_ex_branch_taken(i_ex_branch_taken), .mem(mem4_if.slave),
      .o_pc_en(w4_pc_en), .o_ifid_en(w4_ifid_en), .o_ifid_flush(w4_ifid_flush),
      .o_idex_flush(w4_idex_flush), .o_exmem_en(w4_exmem_en), .o_memwb_flush(w4_memwb_flush),
      .o_error(w4_error), .o_stall_cnt(w4_stall_cnt)
   );

   wire [7:0] outs = {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush,
                      o_exmem_en, o_memwb_flush, mem_if.o_dmem_req, o_error};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are changed.
   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_id(input logic memread, input logic [4:0] idex_rt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic uses_rt, input logic br);
      i_idex_memread    = memread;
      i_idex_rt         = idex_rt;
      i_id_rs           = rs;
      i_id_rt           = rt;
      i_id_uses_rt      = uses_rt;
      i_ex_branch_taken = br;
   endtask

   task automatic set_mem(input logic [1:0] m, input logic ack);
      mem_if.i_exmem_M  = m;
      mem_if.i_dmem_ack = ack;
   endtask

   initial begin
      i_rst = 1'b1;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      set_mem(2'b00, 1'b0);

      // Reset held
      cyc(); #1 chk("reset_outs", 32'(outs), 32'(V_RESET));
      cyc(); #1 chk("reset_stall", 32'(o_stall_cnt), 32'd0);
      i_rst = 1'b0;
      #1 chk("idle_outs", 32'(outs), 32'(V_NORMAL));

      // Load-use on rs
      cyc(); set_id(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
      #1 chk("hazard_rs", 32'(outs), 32'(V_STALL));
      cyc(); set_id(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
      #1 chk("after_hazard", 32'(outs), 32'(V_NORMAL));
      chk("stall_cnt_1", 32'(o_stall_cnt), 32'd1);

      // Branch overrides the same hazard
      cyc(); set_id(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
      #1 chk("branch_over_hazard", 32'(outs), 32'(V_BRANCH));
      // Load to r0 never stalls
      cyc(); set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1 chk("r0_no_stall", 32'(outs), 32'(V_NORMAL));
      chk("stall_after_branch", 32'(o_stall_cnt), 32'd1);

      // rt dependency only counts when rt is read
      cyc(); set_id(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
      #1 chk("hazard_rt", 32'(outs), 32'(V_STALL));
      cyc(); set_id(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
      #1 chk("rt_unused", 32'(outs), 32'(V_NORMAL));
      chk("stall_cnt_2", 32'(o_stall_cnt), 32'd2);
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

      // Access acknowledged immediately
      cyc(); set_mem(2'b01, 1'b1);
      #1 chk("mem_ack_now", 32'(outs), 32'(V_ACKRUN));

      // Read acknowledged after 3 frozen cycles; hazard/branch ignored while waiting
      cyc(); set_mem(2'b01, 1'b0);
      #1 chk("mem_frz0", 32'(outs), 32'(V_FROZEN));
      cyc(); set_id(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
      #1 chk("mem_frz1_ignore", 32'(outs), 32'(V_FROZEN));
      cyc(); set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1 chk("mem_frz2", 32'(outs), 32'(V_FROZEN));
      cyc(); set_mem(2'b01, 1'b1);
      #1 chk("mem_ack_wait", 32'(outs), 32'(V_ACKRUN));
      cyc(); set_mem(2'b00, 1'b0);
      #1 chk("mem_back_run", 32'(outs), 32'(V_NORMAL));
      chk("stall_cnt_5", 32'(o_stall_cnt), 32'd5);

      // Write never acknowledged: first cycle plus 15 wait cycles, then ERR
      cyc(); set_mem(2'b10, 1'b0);
      #1 chk("to_frz_first", 32'(outs), 32'(V_FROZEN));
      for (int i = 1; i <= 15; i++) begin
         cyc(); #1 chk($sformatf("to_wait_%0d", i), 32'(outs), 32'(V_FROZEN));
      end
      cyc(); #1 chk("to_err", 32'(outs), 32'(V_ERR));
      cyc(); set_mem(2'b00, 1'b0);
      #1 chk("err_held", 32'(outs), 32'(V_ERR));
      chk("stall_cnt_22", 32'(o_stall_cnt), 32'd22);
      i_rst = 1'b1;
      #1 chk("reset_from_err", 32'(outs), 32'(V_RSTERR));
      cyc(); i_rst = 1'b0;
      #1 chk("run_after_err", 32'(outs), 32'(V_NORMAL));
      chk("stall_clr_err", 32'(o_stall_cnt), 32'd0);

      // Ack arriving on the limit cycle wins over the timeout
      cyc(); set_mem(2'b01, 1'b0);
      for (int i = 1; i <= 14; i++) begin
         cyc();
      end
      cyc(); set_mem(2'b01, 1'b1);
      #1 chk("ack_at_limit", 32'(outs), 32'(V_ACKRUN));
      cyc(); set_mem(2'b00, 1'b0);
      #1 chk("no_err_after_limit_ack", 32'(outs), 32'(V_NORMAL));

      // Reset in the middle of a memory wait
      cyc(); set_mem(2'b01, 1'b0);
      cyc(); #1 chk("rst_mw_frozen", 32'(outs), 32'(V_FROZEN));
      cyc(); i_rst = 1'b1;
      #1 chk("rst_mw_outs", 32'(outs), 32'(V_RESET));
      cyc(); #1 chk("rst_mw_held", 32'(mem_if.o_dmem_req), 32'd0);
      i_rst = 1'b0;
      set_mem(2'b00, 1'b0);
      #1 chk("rst_mw_run", 32'(outs), 32'(V_NORMAL));
      chk("rst_mw_stall", 32'(o_stall_cnt), 32'd0);
      chk("rst_mw_wait", 32'(dut.wait_cnt_r), 32'd0);

      // 20 stall cycles: 4-bit counter saturates at 15, 16-bit counts on
      cyc(); set_id(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
      for (int i = 1; i < 15; i++) begin
         cyc();
      end
      cyc(); #1 chk("w4_at_15", 32'(w4_stall_cnt), 32'd15);
      for (int i = 0; i < 5; i++) begin
         cyc();
      end
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1 chk("w4_saturated", 32'(w4_stall_cnt), 32'd15);
      chk("w16_at_20", 32'(o_stall_cnt), 32'd20);
      cyc(); #1 chk("w4_no_wrap", 32'(w4_stall_cnt), 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop if the sequence ever stalls.
   initial begin
      #20000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum data-memory wait cycles before error.
REQ-002 SHALL have parameter STALL_CNT_W, default 16: stall counter width.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_id_rs  input  5  source register rs of the instruction in ID.
REQ-006 i_id_rt  input  5  source register rt of the instruction in ID.
REQ-007 i_id_uses_rt  input  1  ID instruction reads rt.
REQ-008 i_idex_memread  input  1  instruction in ID/EX is a load.
REQ-009 i_idex_rt  input  5  load destination register in ID/EX.
REQ-010 i_ex_branch_taken  input  1  branch resolved taken in EX.
REQ-011 i_exmem_M  input  2  EX/MEM memory control; bit1 = write, bit0 = read; 0 means no access.
REQ-012 i_dmem_ack  input  1  data memory completes the current access.
REQ-013 o_pc_en  output  1  PC load enable.
REQ-014 o_ifid_en / o_ifid_flush  output  1 each  IF/ID hold and clear.
REQ-015 o_idex_flush  output  1  ID/EX bubble insert.
REQ-016 o_exmem_en  output  1  EX/MEM load enable.
REQ-017 o_memwb_flush  output  1  MEM/WB bubble insert.
REQ-018 o_dmem_req  output  1  data memory request.
REQ-019 o_error  output  1  sticky memory-timeout flag.
REQ-020 o_stall_cnt  output  STALL_CNT_W  cycles with o_pc_en=0, saturating.

Function
REQ-021 FSM SHALL have states RUN, MEM_WAIT, ERR.
REQ-022 Control outputs SHALL be combinational from state and inputs; FSM, wait counter and stall counter SHALL be registered.
REQ-023 Load-use hazard := i_idex_memread & i_idex_rt!=0 & (i_idex_rt==i_id_rs | (i_id_uses_rt & i_idex_rt==i_id_rt)).
REQ-024 In RUN with a hazard and no taken branch: o_pc_en=0, o_ifid_en=0, o_idex_flush=1 for exactly that cycle; o_exmem_en=1.
REQ-025 In RUN with i_ex_branch_taken: o_ifid_flush=1, o_idex_flush=1, o_pc_en=1; the branch overrides and suppresses a simultaneous load-use stall.
REQ-026 In RUN with i_exmem_M!=0: o_dmem_req=1; if i_dmem_ack=1 in the same cycle, stay in RUN with no stall; otherwise next state is MEM_WAIT and this cycle behaves as in MEM_WAIT.
REQ-027 In MEM_WAIT: o_dmem_req=1, o_pc_en=o_ifid_en=o_exmem_en=0, o_memwb_flush=1, o_idex_flush=0; hazard and branch inputs are ignored (pipeline frozen).
REQ-028 In MEM_WAIT when i_dmem_ack=1: return to RUN; in that cycle enables follow RUN rules and o_memwb_flush=0.
REQ-029 Wait counter SHALL clear on entry to MEM_WAIT and increment each unacknowledged MEM_WAIT cycle; on reaching MEM_TIMEOUT without ack, go to ERR; an ack in the same cycle as the limit wins.
REQ-030 ERR: o_error=1; all enables 0; o_memwb_flush=1; o_dmem_req=0; the state is held until reset.
REQ-031 o_stall_cnt SHALL increment in every cycle with o_pc_en=0, saturating at all-ones without wrapping.
REQ-032 With no hazard, no branch and no memory access: o_pc_en=o_ifid_en=o_exmem_en=1 and all flushes 0.

Reset
REQ-033 i_rst=1 at a clock edge SHALL force RUN, wait counter 0, o_stall_cnt 0, o_error 0, including mid-MEM_WAIT and from ERR.
REQ-034 While i_rst=1: o_pc_en=o_ifid_en=o_exmem_en=0, o_ifid_flush=o_idex_flush=o_memwb_flush=1, o_dmem_req=0.

Structure
REQ-035 Shared package pipeline_pkg SHALL hold the FSM state encoding, the M-field bit positions (MEM_WR=1, MEM_RD=0) and the MEM_TIMEOUT default.
REQ-036 Load-use comparison SHALL be a sub-module hazard_detect (combinational), instantiated once.
REQ-037 Pipeline registers driven by this block SHALL provide enable and flush inputs.

Verification
REQ-038 Load at ID/EX with rt=5, ID rs=5 -> one cycle of o_pc_en=0, o_idex_flush=1, then normal flow; o_stall_cnt=1.
REQ-039 Same hazard with i_ex_branch_taken=1 -> o_ifid_flush=o_idex_flush=1, o_pc_en=1, o_stall_cnt unchanged; with rt=0 -> no stall.
REQ-040 i_exmem_M=01, ack after 3 cycles -> 3 frozen cycles, o_memwb_flush=1 for those 3, RUN after ack, o_stall_cnt=3.
REQ-041 i_exmem_M=10, no ack, MEM_TIMEOUT=15 -> ERR after 15 wait cycles, o_error=1 held; i_rst pulse clears to RUN.
REQ-042 Assert i_rst during MEM_WAIT -> next cycle RUN, counters 0, o_dmem_req=0 while reset is held.
REQ-043 STALL_CNT_W=4, 20 stall cycles -> o_stall_cnt=15, no wrap.
